// File: rtl/dmem_pkg.sv
// Shared types and default constants for the data-memory responder.
// Monitor state encoding and the pass/scratch address defaults of the test program.
package dmem_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } dmem_state_t;

  localparam logic [31:0] DMEM_PASS_ADDR    = 32'd84;
  localparam logic [31:0] DMEM_PASS_DATA    = 32'd7;
  localparam logic [31:0] DMEM_SCRATCH_ADDR = 32'd80;

  // True when a byte address is word aligned and inside a 2^aw-word memory.
  function automatic logic word_ok(input logic [31:0] addr, input int unsigned aw);
    return (addr[1:0] == 2'b00) && ((addr >> (aw + 2)) == 32'd0);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side store/load port: the core drives the master end, the responder the slave end.
// Loads are combinational; there is no backpressure, every store strobe is taken in its cycle.
interface dmem_responder_if;

  logic        memwrite;
  logic [31:0] dataaddr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output memwrite, output dataaddr, output writedata, input readdata);
  modport slave  (input memwrite, input dataaddr, input writedata, output readdata);

endinterface

// File: rtl/dmem_ram.sv
// 2^ADDR_W x 32 word array: write lands on the rising edge, read is combinational.
// No reset, so contents survive a reset of the surrounding logic; never stalls.
module dmem_ram #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the single-cycle core plus a sticky run/pass/fail completion monitor.
// Stores take 1 edge, loads 0 cycles; no backpressure, every strobe is serviced or flagged.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_W       = 6,
  parameter logic [31:0] PASS_ADDR    = DMEM_PASS_ADDR,
  parameter logic [31:0] PASS_DATA    = DMEM_PASS_DATA,
  parameter logic [31:0] SCRATCH_ADDR = DMEM_SCRATCH_ADDR,
  parameter bit          CHECK_EN     = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  dmem_responder_if.slave     bus,
  output logic                addr_err,
  output logic                done,
  output logic                pass,
  output logic [15:0]         wr_count,
  output logic [31:0]         last_wr_addr
);

  // A misplaced PASS_ADDR would make the PASS state unreachable.
  localparam bit PASS_ADDR_OK = (PASS_ADDR[1:0] == 2'b00) &&
                                ((PASS_ADDR >> (ADDR_W + 2)) == 32'd0);

  if (CHECK_EN && !PASS_ADDR_OK) begin : g_pass_addr_chk
    $error("dmem_responder: PASS_ADDR is misaligned or outside the memory");
  end

  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              accept;
  logic [31:0]       ram_rdata;

  dmem_state_t state_q, state_d;
  logic        addr_err_q, addr_err_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic [31:0] last_wr_addr_q, last_wr_addr_d;

  assign idx      = bus.dataaddr[ADDR_W+1:2];
  assign in_range = ((bus.dataaddr >> (ADDR_W + 2)) == 32'd0);
  assign accept   = bus.memwrite && word_ok(bus.dataaddr, ADDR_W);

  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (idx),
    .wdata (bus.writedata),
    .raddr (idx),
    .rdata (ram_rdata)
  );

  // Sub-word offset is ignored on loads; out-of-range loads read as zero.
  assign bus.readdata = in_range ? ram_rdata : 32'h0;

  always_comb begin
    state_d = state_q;
    if (CHECK_EN && (state_q == RUN) && bus.memwrite) begin
      if ((bus.dataaddr == PASS_ADDR) && (bus.writedata == PASS_DATA)) begin
        state_d = PASS;
      end else if ((bus.dataaddr != SCRATCH_ADDR) || !accept) begin
        state_d = FAIL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    addr_err_d     = addr_err_q;
    wr_count_d     = wr_count_q;
    last_wr_addr_d = last_wr_addr_q;
    if (bus.memwrite) begin
      last_wr_addr_d = bus.dataaddr;
      if (!accept) begin
        addr_err_d = 1'b1;
      end else if (wr_count_q != 16'hFFFF) begin
        wr_count_d = wr_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err_q     <= 1'b0;
      wr_count_q     <= 16'd0;
      last_wr_addr_q <= 32'd0;
    end else begin
      addr_err_q     <= addr_err_d;
      wr_count_q     <= wr_count_d;
      last_wr_addr_q <= last_wr_addr_d;
    end
  end

  assign addr_err     = addr_err_q;
  assign done         = (state_q != RUN);
  assign pass         = (state_q == PASS);
  assign wr_count     = wr_count_q;
  assign last_wr_addr = last_wr_addr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: hand-computed expectations for stores, loads,
// monitor transitions, address errors and asynchronous reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        addr_err;
  logic        done;
  logic        pass;
  logic [15:0] wr_count;
  logic [31:0] last_wr_addr;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder_if bus ();

  dmem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .addr_err     (addr_err),
    .done         (done),
    .pass         (pass),
    .wr_count     (wr_count),
    .last_wr_addr (last_wr_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One store strobe: driven at a falling edge, taken at the next rising edge.
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.memwrite  = 1'b1;
    bus.dataaddr  = addr;
    bus.writedata = data;
    @(negedge clk);
    bus.memwrite  = 1'b0;
    #1;
  endtask

  task automatic load(input logic [31:0] addr);
    bus.memwrite = 1'b0;
    bus.dataaddr = addr;
    #1;
  endtask

  // Reset pulse placed between clock edges so its effect is purely asynchronous.
  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst           = 1'b0;
    bus.memwrite  = 1'b0;
    bus.dataaddr  = 32'd0;
    bus.writedata = 32'd0;
    #12;
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_pass",     {31'd0, pass},     32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
    chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
    chk("rst_last_addr", last_wr_addr,     32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Direct pass store.
    store(32'd84, 32'd7);
    chk("t1_done",      {31'd0, done},     32'd1);
    chk("t1_pass",      {31'd0, pass},     32'd1);
    chk("t1_wr_count",  {16'd0, wr_count}, 32'd1);
    chk("t1_last_addr", last_wr_addr,      32'd84);
    load(32'd84);
    chk("t1_read84",    bus.readdata,      32'd7);

    // Asynchronous reset while in PASS; RAM survives.
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_done",     {31'd0, done},     32'd0);
    chk("arst_pass",     {31'd0, pass},     32'd0);
    chk("arst_wr_count", {16'd0, wr_count}, 32'd0);
    chk("arst_last",     last_wr_addr,      32'd0);
    load(32'd84);
    chk("arst_read84",   bus.readdata,      32'd7);
    @(negedge clk);
    rst = 1'b1;

    // Scratch store then pass store.
    store(32'd80, 32'd5);
    chk("t2a_done",     {31'd0, done},     32'd0);
    chk("t2a_wr_count", {16'd0, wr_count}, 32'd1);
    store(32'd84, 32'd7);
    chk("t2b_pass",     {31'd0, pass},     32'd1);
    chk("t2b_wr_count", {16'd0, wr_count}, 32'd2);
    load(32'd80);
    chk("t2_read80",    bus.readdata,      32'd5);

    // Same-cycle load and store: old value before the edge, new after.
    @(negedge clk);
    bus.memwrite  = 1'b1;
    bus.dataaddr  = 32'd80;
    bus.writedata = 32'd9;
    #1;
    chk("fwd_pre",  bus.readdata, 32'd5);
    @(posedge clk);
    #1;
    chk("fwd_post", bus.readdata, 32'd9);
    @(negedge clk);
    bus.memwrite = 1'b0;
    #1;
    chk("fwd_wr_count", {16'd0, wr_count}, 32'd3);
    chk("fwd_pass",     {31'd0, pass},     32'd1);

    // Wrong data to the pass address.
    pulse_reset();
    store(32'd84, 32'd3);
    chk("t3_done",  {31'd0, done}, 32'd1);
    chk("t3_pass",  {31'd0, pass}, 32'd0);
    load(32'd84);
    chk("t3_read84", bus.readdata, 32'd3);
    store(32'd84, 32'd7);
    chk("t3_sticky_pass", {31'd0, pass},     32'd0);
    chk("t3_sticky_done", {31'd0, done},     32'd1);
    chk("t3_wr_count",    {16'd0, wr_count}, 32'd2);

    // Misaligned and out-of-range stores.
    pulse_reset();
    store(32'd82, 32'hDEAD);
    chk("t4_addr_err",  {31'd0, addr_err}, 32'd1);
    chk("t4_wr_count",  {16'd0, wr_count}, 32'd0);
    chk("t4_done",      {31'd0, done},     32'd1);
    chk("t4_pass",      {31'd0, pass},     32'd0);
    chk("t4_last_82",   last_wr_addr,      32'd82);
    load(32'd80);
    chk("t4_read80",    bus.readdata,      32'd9);
    store(32'd256, 32'h1234);
    chk("t4_wr_count2", {16'd0, wr_count}, 32'd0);
    chk("t4_last_256",  last_wr_addr,      32'd256);
    load(32'd256);
    chk("t4_read256",   bus.readdata,      32'd0);
    load(32'd336);
    chk("t4_read336",   bus.readdata,      32'd0);

    // Non-scratch in-range store fails without an address error.
    pulse_reset();
    store(32'd80, 32'd1);
    chk("t5_run",       {31'd0, done},     32'd0);
    store(32'd0, 32'd1);
    chk("t5_done",      {31'd0, done},     32'd1);
    chk("t5_pass",      {31'd0, pass},     32'd0);
    chk("t5_addr_err",  {31'd0, addr_err}, 32'd0);
    chk("t5_wr_count",  {16'd0, wr_count}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle MIPS core: the slave end of the core's store/load port (`memwrite`, `dataaddr`, `writedata`). Services word stores on the clock edge and word loads combinationally. Also runs a sticky run/pass/fail completion monitor, so that synthesised and simulated tops can report program completion without a bench-side checker. Sits beside the core inside `top` and replaces the bare data RAM.

## Interface

Parameters:
- `ADDR_W`, 6: word-index width; memory holds 2^ADDR_W 32-bit words (byte range 0 .. 4·2^ADDR_W−1).
- `PASS_ADDR`, 32'd84: byte address whose store of `PASS_DATA` signals success.
- `PASS_DATA`, 32'd7: value that must be stored to `PASS_ADDR`.
- `SCRATCH_ADDR`, 32'd80: only other byte address the test program is permitted to store to.
- `CHECK_EN`, 1: 1 enables the monitor; 0 holds the monitor in RUN permanently.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `memwrite`, in, 1: store strobe from the core, valid for the whole cycle.
- `dataaddr`, in, 32: byte address (ALU result).
- `writedata`, in, 32: store data.
- `readdata`, out, 32: load data, combinational from `dataaddr`.
- `addr_err`, out, 1: sticky; a store was misaligned or out of range.
- `done`, out, 1: monitor has left RUN.
- `pass`, out, 1: monitor is in PASS.
- `wr_count`, out, 16: number of accepted stores, saturating at 16'hFFFF.
- `last_wr_addr`, out, 32: byte address of the most recent store strobe, accepted or not.

## Operation

- Index: `dataaddr[ADDR_W+1:2]`.
- In range: `dataaddr[31:ADDR_W+2] == 0`.
- Aligned: `dataaddr[1:0] == 0`.
- Store: on rising edge with `memwrite`=1, aligned and in range, write the word and increment `wr_count`. Otherwise, suppress the write, leave `wr_count` unchanged, and set `addr_err`.
- Load: `readdata` = stored word when in range, else 32'h0. `dataaddr[1:0]` is ignored for loads. No write-to-read forwarding: in a store cycle, `readdata` shows the pre-store contents.
- RAM array is not reset. Contents are undefined until written.
- `last_wr_addr` updates on every `memwrite` cycle.
- Monitor FSM, states RUN, PASS, FAIL; evaluated only on `memwrite` cycles while in RUN:
  - `dataaddr`==`PASS_ADDR` and `writedata`==`PASS_DATA` -> PASS.
  - else `dataaddr`!=`SCRATCH_ADDR` or suppressed store -> FAIL.
  - else stay in RUN.
- PASS and FAIL are absorbing until reset. Stores continue to be serviced in them; only the FSM is frozen.
- `done` = (state != RUN); `pass` = (state == PASS).

## Timing

- Reset values (asynchronous, applied while `rst`=0):
  - state = RUN
  - `done` = 0
  - `pass` = 0
  - `addr_err` = 0
  - `wr_count` = 0
  - `last_wr_addr` = 0
- Store latency: 1 edge. The data is visible on `readdata` in the cycle after the edge.
- Load latency: 0 cycles (combinational).
- `done`/`pass`/`addr_err` assert in the cycle after the triggering edge.
- Reset assertion mid-run clears the FSM and counters immediately and leaves RAM contents untouched. The first edge after `rst` rises is a normal cycle.
- A store to `PASS_ADDR` with the wrong data -> FAIL, and the write still lands in RAM.
- If `PASS_ADDR` is misaligned or out of range, PASS is unreachable. This is a parameter error; flag it with an elaboration-time assertion.
- `wr_count` at 16'hFFFF holds its value on further stores.

## Structure

- Package `dmem_pkg`:
  - monitor state enum `dmem_state_t` {RUN, PASS, FAIL}
  - default constants `DMEM_PASS_ADDR`, `DMEM_PASS_DATA`, `DMEM_SCRATCH_ADDR`
- Sub-module `dmem_ram`: the 2^ADDR_W×32 array, with synchronous write port and asynchronous read port. Top level holds decode, the FSM, counters and error flag.

## Test plan

- Reset, then a store of 7 to 84 -> `done`=1 and `pass`=1 on the next cycle; `wr_count`=1.
- A store of 5 to 80, then 7 to 84 -> after the first store, still RUN with `wr_count`=1; after the second, PASS with `wr_count`=2. Reading 80 returns 5.
- A store of 3 to 84 -> FAIL (`done`=1, `pass`=0). Reading 84 returns 3. A subsequent store of 7 to 84 leaves the state at FAIL.
- A store to 82 (misaligned) and a store to 256 with `ADDR_W`=6 -> `addr_err`=1, `wr_count` unchanged, FAIL. A load from 256 returns 0.
- Same-cycle load and store to 80 (old value 5, new value 9) -> `readdata`=5 in that cycle and 9 in the next.
- Drop `rst` low while in PASS -> `done`, `pass` and `wr_count` go to 0 asynchronously, and the RAM word at 84 still reads 7.
